// File: rtl/rate_tick_gen_pkg.sv
// Shared rate-select encodings and default clock rate for the display tick generator.
package rate_tick_gen_pkg;

    localparam logic [1:0] RATE_FULL = 2'b00;
    localparam logic [1:0] RATE_1HZ  = 2'b01;
    localparam logic [1:0] RATE_HALF = 2'b10;
    localparam logic [1:0] RATE_STEP = 2'b11;

    localparam int unsigned DEFAULT_CLK_HZ = 50000000;

endpackage

// File: rtl/rate_tick_gen_step_sync_edge.sv
// Push-button synchronizer: two metastability flops plus an edge flop, giving a
// one-cycle pulse on the falling (press) edge of the active-low button.
module step_sync_edge (
    input  logic clk,
    input  logic clear_b,
    input  logic step_n,
    output logic press_pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= step_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press_pulse = ~s2 & s3;

endmodule

// File: rtl/rate_tick_gen.sv
// Rate-selectable one-cycle enable pulse for the 8-bit display counter:
// every cycle, 1 Hz, 0.5 Hz, or one pulse per push-button press.
module rate_tick_gen
    import rate_tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
    parameter int unsigned CNT_W  = 28
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             en,
    input  logic [1:0]       rate_sel,
    input  logic             step_n,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] PERIOD_1HZ  = CNT_W'(CLK_HZ);
    localparam logic [CNT_W-1:0] PERIOD_HALF = CNT_W'(2 * CLK_HZ);
    localparam logic [CNT_W-1:0] RELOAD_1HZ  = PERIOD_1HZ - CNT_W'(1);
    localparam logic [CNT_W-1:0] RELOAD_HALF = PERIOD_HALF - CNT_W'(1);

    logic [1:0] sel_q;
    logic       press;

    step_sync_edge u_step (
        .clk        (clk),
        .clear_b    (clear_b),
        .step_n     (step_n),
        .press_pulse(press)
    );

    function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] sel);
        case (sel)
            RATE_1HZ:  reload_for = RELOAD_1HZ;
            RATE_HALF: reload_for = RELOAD_HALF;
            default:   reload_for = '0;
        endcase
    endfunction

    // A rate change always wins: it reloads for the new mode and never ticks.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            count <= '0;
            tick  <= 1'b0;
            sel_q <= RATE_FULL;
        end else begin
            sel_q <= rate_sel;
            if (rate_sel != sel_q) begin
                tick  <= 1'b0;
                count <= reload_for(rate_sel);
            end else begin
                case (sel_q)
                    RATE_FULL: begin
                        tick  <= en;
                        count <= '0;
                    end
                    RATE_1HZ, RATE_HALF: begin
                        if (!en) begin
                            tick <= 1'b0;
                        end else if (count == '0) begin
                            tick  <= 1'b1;
                            count <= reload_for(sel_q);
                        end else begin
                            tick  <= 1'b0;
                            count <= count - CNT_W'(1);
                        end
                    end
                    default: begin
                        tick  <= press & en;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Self-checking bench for rate_tick_gen with CLK_HZ=4 (1 Hz period 4, 0.5 Hz period 8).
module tb_rate_tick_gen;

    logic       clk;
    logic       clear_b;
    logic       en;
    logic [1:0] rate_sel;
    logic       step_n;
    logic       tick;
    logic [7:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic       step_n;
        logic       tick;
        int         count;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    rate_tick_gen #(.CLK_HZ(4), .CNT_W(8)) dut (
        .clk     (clk),
        .clear_b (clear_b),
        .en      (en),
        .rate_sel(rate_sel),
        .step_n  (step_n),
        .tick    (tick),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [1:0] s, input logic st, input logic t, input int c);
        vec_t v;
        v.en = e;
        v.sel = s;
        v.step_n = st;
        v.tick = t;
        v.count = c;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        en = v.en;
        rate_sel = v.sel;
        step_n = v.step_n;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d_tick", idx), {31'd0, tick}, {31'd0, e.tick});
        check($sformatf("vec%0d_count", idx), {24'd0, count}, e.count);
    endtask

    initial begin
        int n;

        // Mode 01 from reset: change edge reloads to 3, ticks on edges 5, 9, 13
        for (int i = 1; i <= 13; i++)
            add(1, 2'b01, 1, (i >= 5 && (i % 4) == 1), (4 - (i % 4)) % 4);
        // 01 -> 10 while count=2: no tick on change, reload 7, tick 8 edges later
        add(1, 2'b01, 1, 0, 2);
        add(1, 2'b10, 1, 0, 7);
        for (int c = 6; c >= 0; c--) add(1, 2'b10, 1, 0, c);
        add(1, 2'b10, 1, 1, 7);
        // Mode 10 with a 3-cycle pause: interval becomes 11
        add(1, 2'b10, 1, 0, 6);
        add(1, 2'b10, 1, 0, 5);
        add(1, 2'b10, 1, 0, 4);
        for (int i = 0; i < 3; i++) add(0, 2'b10, 1, 0, 4);
        for (int c = 3; c >= 0; c--) add(1, 2'b10, 1, 0, c);
        add(1, 2'b10, 1, 1, 7);
        // Mode 00: tick follows en one edge later
        add(1, 2'b00, 1, 0, 0);
        add(1, 2'b00, 1, 1, 0);
        add(1, 2'b00, 1, 1, 0);
        add(0, 2'b00, 1, 0, 0);
        add(1, 2'b00, 1, 1, 0);
        // Mode 11: long press gives one tick at fall+2, none on release
        add(1, 2'b11, 1, 0, 0);
        add(1, 2'b11, 1, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 2'b11, 0, (i == 2), 0);
        for (int i = 0; i < 4; i++) add(1, 2'b11, 1, 0, 0);
        add(1, 2'b11, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0);
        add(1, 2'b11, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 2'b11, 1, 0, 0);
        // Press while en=0 is dropped, not replayed when en returns
        for (int i = 0; i < 3; i++) add(0, 2'b11, 0, 0, 0);
        add(1, 2'b11, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 2'b11, 1, 0, 0);
        // Back to mode 01, stop on a tick edge for the async reset check
        add(1, 2'b01, 1, 0, 3);
        add(1, 2'b01, 1, 0, 2);
        add(1, 2'b01, 1, 0, 1);
        add(1, 2'b01, 1, 0, 0);
        add(1, 2'b01, 1, 1, 3);

        clear_b = 1'b0;
        en = 1'b1;
        rate_sel = 2'b01;
        step_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_count", {24'd0, count}, 32'd0);
        clear_b = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous clear between edges while tick=1
        #2;
        clear_b = 1'b0;
        #1;
        check("async_clear_tick", {31'd0, tick}, 32'd0);
        check("async_clear_count", {24'd0, count}, 32'd0);
        @(posedge clk);
        #1;
        clear_b = 1'b1;

        // Restart after clear: first tick PERIOD+1 edges after release
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("restart_latency", n, 32'd5);
        check("restart_count", {24'd0, count}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
